// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and address helpers for the instruction memory.
`default_nettype none

package imem_pkg;

  typedef enum logic {CLEAR, RUN} imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word index of a byte address; upper bits wrap modulo depth.
  function automatic logic [31:0] word_idx(input logic [63:0] addr, input int unsigned depth);
    return 32'((addr >> 2) % 64'(depth));
  endfunction

  function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < 64'(depth) * 64'd4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// imem_array: DEPTH x XLEN storage, one synchronous read port and one write port, read-before-write.
`default_nettype none

module imem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [XLEN-1:0] rdata,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Contents are zeroed by the controller's sweep, so the array itself has no reset.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with 1-cycle fetch, program-load port and post-reset clear sweep.
// Optional INSTR_MEM_FAULT_EN: fault/NOP on misaligned or out-of-range fetch, drop such loads.
`default_nettype none

module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [AW-1:0]   fetch_addr,
  output logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_instr,
  output logic            fetch_fault,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic            busy
);

  localparam int IW = $clog2(DEPTH);

  imem_state_t     state;
  logic [IW-1:0]   clr_cnt;
  logic            ready;
  logic            sel_nop;
  logic            fetch_acc;
  logic            load_acc;
  logic            fetch_ok;
  logic            load_ok;
  logic [IW-1:0]   fetch_idx;
  logic [IW-1:0]   load_idx;
  logic            mem_we;
  logic [IW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  assign fetch_idx = IW'(word_idx(64'(fetch_addr), DEPTH));
  assign load_idx  = IW'(word_idx(64'(load_addr), DEPTH));

`ifdef INSTR_MEM_FAULT_EN
  assign fetch_ok = addr_ok(64'(fetch_addr), DEPTH);
  assign load_ok  = addr_ok(64'(load_addr), DEPTH);
`else
  assign fetch_ok = 1'b1;
  assign load_ok  = 1'b1;
`endif

  assign fetch_ready = ready;
  assign load_ready  = ready;
  assign fetch_acc   = fetch_req && ready;
  assign load_acc    = load_we && ready && load_ok;

  // The sweep owns the single write port while clearing; loads are not accepted then.
  assign mem_we    = (state == CLEAR) || load_acc;
  assign mem_waddr = (state == CLEAR) ? clr_cnt : load_idx;
  assign mem_wdata = (state == CLEAR) ? '0 : load_data;

  imem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .clr   (reset),
    .re    (fetch_acc),
    .raddr (fetch_idx),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata)
  );

  // sel_nop only changes on an accepted fetch so fetch_instr holds between responses.
  assign fetch_instr = sel_nop ? XLEN'(NOP_INSTR) : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      busy        <= 1'b1;
      ready       <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      sel_nop     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + IW'(1);
          if (clr_cnt == IW'(DEPTH - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
      fetch_valid <= fetch_acc;
      fetch_fault <= fetch_acc && !fetch_ok;
      if (fetch_acc)
        sel_nop <= !fetch_ok;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed scenarios plus random traffic against a behavioural memory model.
`default_nettype none

module tb_instr_mem_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            fetch_req = 1'b0;
  logic [AW-1:0]   fetch_addr = '0;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_instr;
  logic            fetch_fault;
  logic            load_we = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [XLEN-1:0] load_data = '0;
  logic            load_ready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mdl_mem [DEPTH];
  int          clear_left = DEPTH;
  logic        e_valid = 1'b0;
  logic        e_fault = 1'b0;
  logic [31:0] e_instr = '0;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ok(input logic [31:0] a);
`ifdef INSTR_MEM_FAULT_EN
    return (a % 4 == 0) && (a < DEPTH * 4);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    bit rdy;
    @(posedge clk);
    if (reset) begin
      clear_left = DEPTH;
      e_valid = 1'b0;
      e_fault = 1'b0;
      e_instr = '0;
      foreach (mdl_mem[i]) mdl_mem[i] = '0;
    end else begin
      rdy = (clear_left == 0);
      if (fetch_req && rdy) begin
        e_valid = 1'b1;
        e_fault = !m_ok(fetch_addr);
        e_instr = e_fault ? 32'h0000_0013 : mdl_mem[m_idx(fetch_addr)];
      end else begin
        e_valid = 1'b0;
        e_fault = 1'b0;
      end
      if (load_we && rdy && m_ok(load_addr))
        mdl_mem[m_idx(load_addr)] = load_data;
      if (clear_left > 0) clear_left--;
    end
    #1;
    check("busy",        64'(busy),        64'(clear_left > 0));
    check("fetch_ready", 64'(fetch_ready), 64'(clear_left == 0));
    check("load_ready",  64'(load_ready),  64'(clear_left == 0));
    check("fetch_valid", 64'(fetch_valid), 64'(e_valid));
    check("fetch_fault", 64'(fetch_fault), 64'(e_fault));
    check("fetch_instr", 64'(fetch_instr), 64'(e_instr));
  endtask

  task automatic drive(input bit rst, input bit freq, input logic [31:0] fa,
                       input bit lwe, input logic [31:0] la, input logic [31:0] ld);
    reset      = rst;
    fetch_req  = freq;
    fetch_addr = fa;
    load_we    = lwe;
    load_addr  = la;
    load_data  = ld;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (mdl_mem[i]) mdl_mem[i] = '0;

    // Reset and full sweep, then every word reads zero
    drive(1, 0, 0, 0, 0, 0);
    idle(DEPTH);
    for (int a = 0; a < DEPTH * 4; a += 4) drive(0, 1, a, 0, 0, 0);
    idle(1);

    // Load then back-to-back fetch
    drive(0, 0, 0, 1, 32'h0, 32'h0000_0033);
    drive(0, 0, 0, 1, 32'h4, 32'h0020_80B3);
    drive(0, 1, 32'h0, 0, 0, 0);
    drive(0, 1, 32'h4, 0, 0, 0);
    idle(2);

    // Same-cycle load and fetch of one word
    drive(0, 0, 0, 1, 32'h4, 32'h1111_1111);
    drive(0, 1, 32'h4, 1, 32'h4, 32'h2222_2222);
    drive(0, 1, 32'h4, 0, 0, 0);
    idle(1);

    // Boundary addresses: wrap without the fault option, fault/NOP with it
    drive(0, 1, 32'h80, 0, 0, 0);
    drive(0, 1, 32'h6, 0, 0, 0);
    drive(0, 1, 32'h2, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 1, 32'h80, 32'hDEAD_BEEF);
    drive(0, 1, 32'h0, 0, 0, 0);
    idle(1);

    // Reset with a response pending and a load in flight
    drive(0, 1, 32'h8, 1, 32'hC, 32'hCAFE_F00D);
    drive(1, 1, 32'hC, 1, 32'hC, 32'h1234_5678);
    idle(DEPTH);
    drive(0, 1, 32'hC, 0, 0, 0);
    idle(1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] fa, la;
      fa = $urandom_range(0, DEPTH * 8 - 1);
      la = $urandom_range(0, DEPTH * 8 - 1);
      if ($urandom_range(0, 9) < 7) fa[1:0] = 2'b00;
      if ($urandom_range(0, 9) < 7) la[1:0] = 2'b00;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, fa,
            $urandom_range(0, 2) == 0, la, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
